// File: rtl/terminal_uart_tx.sv
// Terminal output back end: FIFO-buffered bytes shifted out as 8N1 UART frames.
// state | meaning: IDLE line high | START start bit | DATA data bits LSB first | STOP stop bit
module terminal_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   output logic                     tx,
   output logic                     busy,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [2:0]      idx, idx_next;
   logic [7:0]      shift, shift_next;
   logic            tx_next;
   logic [PW-1:0]   rptr, wptr;
   logic [7:0]      mem [DEPTH];
   logic            pop, push, last_cnt;
   logic [LW-1:0]   level_next;

   assign last_cnt   = (cnt == CW'(CLKS_PER_BIT - 1));
   assign pop        = (level != '0) && ((state == IDLE) || ((state == STOP) && last_cnt));
   // A full FIFO still takes a byte when the shifter drains one on the same edge.
   assign push       = wr_en && ((level != LW'(DEPTH)) || pop);
   assign level_next = level + LW'(push) - LW'(pop);
   assign full       = (level == LW'(DEPTH));

   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      idx_next   = idx;
      shift_next = shift;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (pop) begin
               shift_next = mem[rptr];
               state_next = START;
            end
         end
         START: begin
            if (last_cnt) begin
               cnt_next   = '0;
               idx_next   = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (last_cnt) begin
               cnt_next   = '0;
               shift_next = shift >> 1;
               if (idx == 3'd7) state_next = STOP;
               else             idx_next   = idx + 3'd1;
            end
         end
         STOP: begin
            if (last_cnt) begin
               cnt_next = '0;
               if (pop) begin
                  shift_next = mem[rptr];
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         level    <= '0;
         overflow <= 1'b0;
         rptr     <= '0;
         wptr     <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         idx   <= idx_next;
         shift <= shift_next;
         tx    <= tx_next;
         busy  <= (state_next != IDLE) || (level_next != '0);
         level <= level_next;
         if (wr_en && !push) overflow <= 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push) wptr <= wptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) mem[wptr] <= wr_data;
   end

endmodule

// File: tb/tb_terminal_uart_tx.sv
// Randomized scoreboard bench for terminal_uart_tx against a frame-level model.
module tb_terminal_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          tx;
   logic          busy;
   logic          full;
   logic [LW-1:0] level;
   logic          overflow;

   terminal_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data),
      .tx(tx), .busy(busy), .full(full), .level(level), .overflow(overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total  = 0;
   int passed = 0;

   // Reference model: pending bytes, byte on the line, cycles left in its frame.
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic [7:0] cur = 8'h00;
   int         rem = 0;
   bit         movf = 1'b0;
   int         model_frames = 0;
   int         frames_rx = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
   endtask

   function automatic int model_tx();
      int pos;
      int b;
      if (rem == 0) return 1;
      pos = 10 * CPB - rem;
      b   = pos / CPB;
      if (b == 0) return 0;
      if (b == 9) return 1;
      return int'(cur[b-1]);
   endfunction

   task automatic step(input bit r, input bit w, input logic [7:0] d);
      bit p;
      bit acc;
      rst = r; wr_en = w; wr_data = d;
      if (r) begin
         if (rem > 0) model_frames--;
         mq.delete();
         exp_q.delete();
         rem  = 0;
         movf = 1'b0;
      end else begin
         p   = (mq.size() > 0) && (rem <= 1);
         acc = w && ((mq.size() < DEPTH) || p);
         if (w && !acc) movf = 1'b1;
         if (p) begin
            cur = mq.pop_front();
            rem = 10 * CPB;
            model_frames++;
         end else if (rem > 0) begin
            rem--;
         end
         if (acc) begin
            mq.push_back(d);
            exp_q.push_back(d);
         end
      end
      @(posedge clk);
      #1;
      check("tx",       int'(tx),       model_tx());
      check("level",    int'(level),    mq.size());
      check("full",     int'(full),     int'(mq.size() == DEPTH));
      check("busy",     int'(busy),     int'((rem > 0) || (mq.size() > 0)));
      check("overflow", int'(overflow), int'(movf));
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 2000 && !(rem == 0 && mq.size() == 0); i++) step(1'b0, 1'b0, 8'h00);
      if (!(rem == 0 && mq.size() == 0)) begin
         total++;
         $display("FAIL drain_timeout: model still busy rem=%0d pending=%0d", rem, mq.size());
      end
      repeat (3) step(1'b0, 1'b0, 8'h00);
   endtask

   // Line monitor: decodes frames from tx and pops the scoreboard.
   int         mcnt = 0;
   bit         mact = 1'b0;
   logic [7:0] mbyte = 8'h00;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mact = 1'b0;
      end else if (!mact) begin
         if (tx === 1'b0) begin
            mact = 1'b1;
            mcnt = 0;
         end
      end else begin
         mcnt++;
         if (mcnt == CPB / 2) check("start_bit", int'(tx), 0);
         if (mcnt > CPB && mcnt < 9 * CPB && ((mcnt - CPB / 2) % CPB) == 0)
            mbyte[(mcnt - CPB / 2) / CPB - 1] = tx;
         if (mcnt == 9 * CPB + CPB / 2) begin
            check("stop_bit", int'(tx), 1);
            frames_rx++;
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_frame: got byte %0h expected none", mbyte);
            end else begin
               check("rx_byte", int'(mbyte), int'(exp_q.pop_front()));
            end
            mact = 1'b0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;

      // reset held with writes pulsing
      step(1'b1, 1'b1, 8'($urandom));
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'($urandom));
      repeat (6) step(1'b0, 1'b0, 8'h00);

      // single byte
      step(1'b0, 1'b1, 8'h41);
      drain();

      // back-to-back
      step(1'b0, 1'b1, 8'h55);
      step(1'b0, 1'b1, 8'hAA);
      drain();

      // overflow: six writes from idle, sixth dropped
      for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'($urandom));
      drain();
      step(1'b1, 1'b0, 8'h00);

      // full with simultaneous pop on last stop-bit cycle
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'($urandom));
      for (i = 0; i < 200 && rem != 1; i++) step(1'b0, 1'b0, 8'h00);
      check("reached_last_stop", rem, 1);
      check("fifo_full_before", int'(full), 1);
      step(1'b0, 1'b1, 8'hC3);
      check("level_after_full_pop", int'(level), DEPTH);
      drain();

      // reset during data bit 3
      step(1'b0, 1'b1, 8'($urandom));
      for (i = 0; i < 200 && (rem == 0 || (10 * CPB - rem) != 17); i++) step(1'b0, 1'b0, 8'h00);
      check("reached_data_bit3", 10 * CPB - rem, 17);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h0F);
      drain();

      // randomized traffic including overruns
      for (int k = 0; k < 600; k++) step(1'b0, ($urandom_range(0, 99) < 9), 8'($urandom));
      drain();

      check("frames_received", frames_rx, model_frames);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
